// File: rtl/nem_ohmux_seq.sv
// Sequenced one-hot inverting mux driving a NEM-relay select fabric with break-before-make control.
// Latency: new connection BREAK_CYC+MAKE_CYC cycles to LOCKED/DONE; off BREAK_CYC; no-op/reject 1 cycle.
// Backpressure: SEL_READY is high only in IDLE; requests made while busy are dropped, never queued.
//
// Ports:
//   CP, CDN          clock (rising edge) and asynchronous active-low reset
//   I                N_IN packed buses, bus k at I[k*WIDTH +: WIDTH]
//   SEL_IDX/SEL_OFF  requested bus index, or request to open every relay
//   SEL_VALID/READY  request handshake, accepted when both are high on a rising edge
//   S                registered relay drive, one-hot or all-zero
//   ZN               inverted selected bus, all ones while no relay is closed
//   LOCKED           a relay is closed and has settled
//   DONE/ERR         one-cycle completion / rejection pulses
module nem_ohmux_seq #(
    parameter int N_IN      = 4,
    parameter int WIDTH     = 8,
    parameter int BREAK_CYC = 2,
    parameter int MAKE_CYC  = 3,
    parameter int IDXW      = ($clog2(N_IN) > 1) ? $clog2(N_IN) : 1
) (
    input  logic                    CP,
    input  logic                    CDN,
    input  logic [N_IN*WIDTH-1:0]   I,
    input  logic [IDXW-1:0]         SEL_IDX,
    input  logic                    SEL_OFF,
    input  logic                    SEL_VALID,
    output logic                    SEL_READY,
    output logic [N_IN-1:0]         S,
    output logic [WIDTH-1:0]        ZN,
    output logic                    LOCKED,
    output logic                    DONE,
    output logic                    ERR
);

    // Shared BREAK/MAKE down-counter must hold the larger of the two reload values.
    localparam int CMAX = (BREAK_CYC > MAKE_CYC) ? BREAK_CYC : MAKE_CYC;
    localparam int CNTW = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CNTW-1:0] BRK_LOAD = CNTW'(BREAK_CYC - 1);
    localparam logic [CNTW-1:0] MK_LOAD  = CNTW'(MAKE_CYC - 1);

    // One extra bit so N_IN itself is representable when N_IN is a power of two.
    localparam logic [IDXW:0] N_IN_L = (IDXW + 1)'(N_IN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BREAK = 2'd1,
        MAKE  = 2'd2
    } state_t;

    state_t            state;
    logic [CNTW-1:0]   cnt;
    logic [IDXW-1:0]   pend_idx;
    logic              pend_off;

    logic              idx_bad;
    logic [N_IN-1:0]   req_oh;
    logic [N_IN-1:0]   pend_oh;
    logic [WIDTH-1:0]  sel_or;

    assign SEL_READY = (state == IDLE);
    assign idx_bad   = ({1'b0, SEL_IDX} >= N_IN_L);
    assign req_oh    = N_IN'(1) << SEL_IDX;
    assign pend_oh   = N_IN'(1) << pend_idx;

    // AND-OR mux over the relay drive; an open fabric reads as all zeros, so ZN is all ones.
    always_comb begin
        sel_or = '0;
        for (int k = 0; k < N_IN; k++) begin
            sel_or = sel_or | ({WIDTH{S[k]}} & I[k*WIDTH +: WIDTH]);
        end
    end

    assign ZN = ~sel_or;

    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            state    <= IDLE;
            cnt      <= '0;
            pend_idx <= '0;
            pend_off <= 1'b0;
            S        <= '0;
            LOCKED   <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;
            case (state)
                IDLE: begin
                    if (SEL_VALID) begin
                        if (!SEL_OFF && idx_bad) begin
                            ERR <= 1'b1;
                        end else if (!SEL_OFF && LOCKED && (S == req_oh)) begin
                            // Already connected where asked: no need to cycle the relays.
                            DONE <= 1'b1;
                        end else if (SEL_OFF && (S == '0)) begin
                            DONE <= 1'b1;
                        end else begin
                            // Open everything first; the new relay only closes after BREAK.
                            S        <= '0;
                            LOCKED   <= 1'b0;
                            cnt      <= BRK_LOAD;
                            pend_idx <= SEL_IDX;
                            pend_off <= SEL_OFF;
                            state    <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (cnt == '0) begin
                        if (pend_off) begin
                            DONE  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            S     <= pend_oh;
                            cnt   <= MK_LOAD;
                            state <= MAKE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                MAKE: begin
                    if (cnt == '0) begin
                        LOCKED <= 1'b1;
                        DONE   <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nem_ohmux_seq.sv
module tb_nem_ohmux_seq;

    logic        CP  = 1'b0;
    logic        CDN = 1'b0;
    logic [31:0] I;
    logic [1:0]  SEL_IDX;
    logic        SEL_OFF;
    logic        SEL_VALID;
    logic        SEL_READY;
    logic [3:0]  S;
    logic [7:0]  ZN;
    logic        LOCKED;
    logic        DONE;
    logic        ERR;

    // Three-input instance: gives an index (3) that is out of range but still drivable.
    logic [23:0] I2;
    logic [1:0]  SEL_IDX2;
    logic        SEL_OFF2;
    logic        SEL_VALID2;
    logic        SEL_READY2;
    logic [2:0]  S2;
    logic [7:0]  ZN2;
    logic        LOCKED2;
    logic        DONE2;
    logic        ERR2;

    nem_ohmux_seq #(.N_IN(4), .WIDTH(8), .BREAK_CYC(2), .MAKE_CYC(3)) dut (
        .CP(CP), .CDN(CDN), .I(I), .SEL_IDX(SEL_IDX), .SEL_OFF(SEL_OFF),
        .SEL_VALID(SEL_VALID), .SEL_READY(SEL_READY), .S(S), .ZN(ZN),
        .LOCKED(LOCKED), .DONE(DONE), .ERR(ERR)
    );

    nem_ohmux_seq #(.N_IN(3), .WIDTH(8), .BREAK_CYC(2), .MAKE_CYC(3)) dut3 (
        .CP(CP), .CDN(CDN), .I(I2), .SEL_IDX(SEL_IDX2), .SEL_OFF(SEL_OFF2),
        .SEL_VALID(SEL_VALID2), .SEL_READY(SEL_READY2), .S(S2), .ZN(ZN2),
        .LOCKED(LOCKED2), .DONE(DONE2), .ERR(ERR2)
    );

    always #5 CP = ~CP;

    int cyc = 0;
    always @(posedge CP) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int         cyc;
        bit         err;
        logic [3:0] s;
        logic       lk;
        logic [7:0] zn;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;
    logic [3:0] s_prev;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Output side of the scoreboard: every DONE/ERR pulse must match the head entry.
    always @(negedge CP) begin
        if (!CDN) begin
            s_prev = '0;
        end else begin
            chk("onehot", 32'($countones(S) <= 1), 32'd1);
            chk("bbm", 32'((s_prev != 0) && (S != 0) && (S != s_prev)), 32'd0);
            s_prev = S;
            if (DONE || ERR) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_pulse", 32'({DONE, ERR}), 32'd0);
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("pulse_cyc", 32'(cyc), 32'(e_mon.cyc));
                    chk("pulse_kind", 32'({DONE, ERR}), e_mon.err ? 32'd1 : 32'd2);
                    chk("pulse_s", 32'(S), 32'(e_mon.s));
                    chk("pulse_locked", 32'(LOCKED), 32'(e_mon.lk));
                    chk("pulse_zn", 32'(ZN), 32'(e_mon.zn));
                end
            end
        end
    end

    // Drive one request (caller is between edges); lat < 0 means no completion expected.
    task automatic send(input logic [1:0] idx, input logic off, input int lat, input bit err,
                        input logic [3:0] s, input logic lk, input logic [7:0] zn);
        exp_t r;
        SEL_IDX   = idx;
        SEL_OFF   = off;
        SEL_VALID = 1'b1;
        chk("ready", 32'(SEL_READY), 32'd1);
        @(posedge CP);
        #1;
        if (lat >= 0) begin
            r.cyc = cyc + lat;
            r.err = err;
            r.s   = s;
            r.lk  = lk;
            r.zn  = zn;
            exp_q.push_back(r);
        end
        @(negedge CP);
        SEL_VALID = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge CP);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            chk(tag, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        I          = $urandom;
        SEL_IDX    = '0;
        SEL_OFF    = 1'b0;
        SEL_VALID  = 1'b0;
        I2         = 24'h3CA581;
        SEL_IDX2   = '0;
        SEL_OFF2   = 1'b0;
        SEL_VALID2 = 1'b0;

        // Reset held across a clock edge with random data on the buses.
        #3;
        chk("rst_s", 32'(S), 32'd0);
        chk("rst_zn", 32'(ZN), 32'hFF);
        chk("rst_locked", 32'(LOCKED), 32'd0);
        chk("rst_pulses", 32'({DONE, ERR}), 32'd0);
        #5;
        I = $urandom;
        #1;
        chk("rst_zn2", 32'(ZN), 32'hFF);
        chk("rst_s2", 32'(S2), 32'd0);
        @(negedge CP);
        CDN = 1'b1;
        #1;
        chk("rst_ready", 32'(SEL_READY), 32'd1);
        I = 32'h0F3CA581;   // bus3=0F bus2=3C bus1=A5 bus0=81
        @(negedge CP);

        // Connect to bus 2.
        send(2'd2, 1'b0, 5, 1'b0, 4'b0100, 1'b1, 8'hC3);
        chk("con_s_t0", 32'(S), 32'd0);
        @(negedge CP);
        chk("con_s_t1", 32'(S), 32'd0);
        @(negedge CP);
        chk("con_s_t2", 32'(S), 32'h4);
        chk("con_lk_t2", 32'(LOCKED), 32'd0);
        wait_idle("con_timeout");

        // Switch to bus 1, issued in the DONE cycle of the previous request.
        send(2'd1, 1'b0, 5, 1'b0, 4'b0010, 1'b1, 8'h5A);
        chk("sw_s_t0", 32'(S), 32'd0);
        @(negedge CP);
        chk("sw_s_t1", 32'(S), 32'd0);
        @(negedge CP);
        chk("sw_s_t2", 32'(S), 32'h2);
        wait_idle("sw_timeout");

        // Switch to bus 3 with a competing request held through MAKE.
        send(2'd3, 1'b0, 5, 1'b0, 4'b1000, 1'b1, 8'hF0);
        @(negedge CP);
        @(negedge CP);
        SEL_IDX   = 2'd0;
        SEL_VALID = 1'b1;
        #1;
        chk("busy_ready_a", 32'(SEL_READY), 32'd0);
        @(negedge CP);
        chk("busy_ready_b", 32'(SEL_READY), 32'd0);
        @(negedge CP);
        SEL_VALID = 1'b0;
        wait_idle("busy_timeout");
        repeat (3) @(negedge CP);
        chk("busy_dropped", 32'(S), 32'h8);

        // Re-request of the current bus completes at once without a break.
        send(2'd3, 1'b0, 0, 1'b0, 4'b1000, 1'b1, 8'hF0);
        @(negedge CP);
        chk("same_nobreak", 32'(S), 32'h8);
        wait_idle("same_timeout");

        // ZN follows the selected bus combinationally.
        I[31:24] = 8'h5A;
        #1;
        chk("zn_follow", 32'(ZN), 32'hA5);
        I[31:24] = 8'h0F;
        #1;

        // Open all relays, then ask again while already open.
        send(2'd0, 1'b1, 2, 1'b0, 4'b0000, 1'b0, 8'hFF);
        chk("off_s_t0", 32'(S), 32'd0);
        chk("off_zn_t0", 32'(ZN), 32'hFF);
        wait_idle("off_timeout");
        send(2'd0, 1'b1, 0, 1'b0, 4'b0000, 1'b0, 8'hFF);
        wait_idle("off2_timeout");

        // Out-of-range index on the three-input instance while it is locked on bus 1.
        SEL_IDX2   = 2'd1;
        SEL_VALID2 = 1'b1;
        @(posedge CP);
        #1;
        SEL_VALID2 = 1'b0;
        repeat (6) @(negedge CP);
        chk("inv_pre_s", 32'(S2), 32'h2);
        chk("inv_pre_lk", 32'(LOCKED2), 32'd1);
        chk("inv_pre_zn", 32'(ZN2), 32'h5A);
        SEL_IDX2   = 2'd3;
        SEL_VALID2 = 1'b1;
        @(posedge CP);
        #1;
        chk("inv_err", 32'(ERR2), 32'd1);
        chk("inv_done", 32'(DONE2), 32'd0);
        chk("inv_s", 32'(S2), 32'h2);
        SEL_VALID2 = 1'b0;
        @(posedge CP);
        #1;
        chk("inv_err_len", 32'(ERR2), 32'd0);
        chk("inv_ready", 32'(SEL_READY2), 32'd1);
        @(negedge CP);

        // Reset one cycle after S goes one-hot: request is abandoned.
        send(2'd0, 1'b0, -1, 1'b0, 4'b0001, 1'b1, 8'h7E);
        @(negedge CP);
        @(negedge CP);
        chk("mrst_pre_s", 32'(S), 32'h1);
        @(negedge CP);
        CDN = 1'b0;
        #1;
        chk("mrst_s", 32'(S), 32'd0);
        chk("mrst_zn", 32'(ZN), 32'hFF);
        chk("mrst_lk", 32'(LOCKED), 32'd0);
        chk("mrst_done", 32'(DONE), 32'd0);
        repeat (2) @(negedge CP);
        CDN = 1'b1;
        repeat (8) @(negedge CP);
        chk("mrst_idle_s", 32'(S), 32'd0);
        send(2'd2, 1'b0, 5, 1'b0, 4'b0100, 1'b1, 8'hC3);
        wait_idle("mrst_timeout");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
